run_sequencer: RTL
==================

// Module: run_sequencer
// PURPOSE
// Host-side initiator for the processor's Reset/Start/Ack run handshake. On Go it
// pulses DutReset once, then launches programs 0..NumProgs-1 back-to-back: pulse
// DutStart, wait for DutAck, report the cycle count. It sits between the bench or
// host and the processor top level and can be synthesised next to it.
// PARAMETERS
// PW        2        width of program index / NumProgs
// CW        16       cycle counter width
// RST_LEN   2        DutReset high time, cycles (>=1)
// START_LEN 2        DutStart high time, cycles (>=1)
// TIMEOUT   16'hFFFF max WAIT cycles before abort (< 2**CW)
// PORTS
// Clk        in  1   clock, posedge
// Reset      in  1   synchronous, active-high
// Go         in  1   launch request, sampled only in IDLE
// NumProgs   in  PW  programs to run, latched on Go; 0 means 2**PW
// DutReset   out 1   to processor Reset
// DutStart   out 1   to processor Start
// DutAck     in  1   processor done flag (combinational in DUT, may glitch high early)
// ProgIdx    out PW  index of program currently running or being reported
// CycleCount out CW  WAIT cycles of last program; valid with CountValid
// CountValid out 1   one-cycle strobe per completed program
// Busy       out 1   high in every state except IDLE
// Done       out 1   high in DONE; held until the next Go
// Timeout    out 1   sticky; set on abort, cleared on Go or Reset
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; internal counters 0. Reset mid-run aborts
//   immediately (no pending strobes), DutReset/DutStart drop on the next edge.
// - All outputs are registered. FSM: IDLE->RST->START->WAIT->REPORT->(START|DONE).
// - IDLE: Go=1 -> latch NumProgs, ProgIdx<=0, clear Done/Timeout, go RST.
// - RST: DutReset=1 for exactly RST_LEN cycles, then START. Done once per Go only.
// - START: DutStart=1 for exactly START_LEN cycles; DutAck ignored here (stale
//   halt flag from previous program). Then WAIT, cycle counter <=0.
// - WAIT: each cycle DutAck=0 -> counter+1. DutAck=1 -> CycleCount<=counter,
//   go REPORT. Ack on first WAIT cycle gives CycleCount=0. Counter==TIMEOUT
//   with DutAck=0 -> Timeout<=1, CycleCount<=TIMEOUT, go DONE (no CountValid).
// - REPORT: CountValid=1 for one cycle. If ProgIdx==last (latched NumProgs-1,
//   mod 2**PW) -> DONE; else ProgIdx+1, -> START (no second DutReset).
// - DONE: Done=1, Busy=0; Go=1 here restarts exactly as from IDLE (DONE->RST).
// - Go while Busy is ignored. DutAck=1 and counter==TIMEOUT in the same cycle:
//   Ack wins (REPORT). Counter never wraps; saturates at TIMEOUT by construction.
// - Latency Go->DutReset high: 1 cycle. Ack sampled->CountValid: 1 cycle.
// - CycleCount and ProgIdx hold their values until overwritten.
// TESTING
// - Reset held 3 cycles -> all outputs 0, state IDLE; Go during Reset ignored.
// - NumProgs=1, Go; DUT model raises Ack 10 cycles into WAIT -> DutReset 2 cycles,
//   DutStart 2 cycles, CountValid once with CycleCount=10, ProgIdx=0, then Done=1.
// - NumProgs=3, Ack delays 5/0/7 -> three strobes ProgIdx 0,1,2, counts 5,0,7;
//   DutReset pulsed once only; Ack held high during START is ignored.
// - NumProgs=0 (PW=2) -> four programs run, ProgIdx 0..3, then Done.
// - TIMEOUT=20, Ack never rises -> Timeout=1, Done=1, CycleCount=20, no CountValid;
//   next Go clears Timeout and reruns.
// - Reset asserted in WAIT of program 1 -> next cycle IDLE, outputs 0, no strobe.

Source files
------------

// File: rtl/run_sequencer.sv
// Host-side driver for the processor Reset/Start/Ack run handshake: one DutReset pulse per
// Go, then programs 0..NumProgs-1 launched back-to-back with per-program WAIT cycle counts.
module run_sequencer #(
  parameter int unsigned PW        = 2,
  parameter int unsigned CW        = 16,
  parameter int unsigned RST_LEN   = 2,
  parameter int unsigned START_LEN = 2,
  parameter int unsigned TIMEOUT   = 16'hFFFF
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          go_i,
  input  logic [PW-1:0] num_progs_i,
  output logic          dut_reset_o,
  output logic          dut_start_o,
  input  logic          dut_ack_i,
  output logic [PW-1:0] prog_idx_o,
  output logic [CW-1:0] cycle_count_o,
  output logic          count_valid_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          timeout_o
);

  localparam int unsigned PhMax = (RST_LEN > START_LEN) ? RST_LEN : START_LEN;
  localparam int unsigned PhW   = $clog2(PhMax + 1);
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);
  localparam logic [PhW-1:0] RstLast   = PhW'(RST_LEN - 1);
  localparam logic [PhW-1:0] StartLast = PhW'(START_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StRst,
    StStart,
    StWait,
    StReport,
    StDone
  } state_e;

  state_e         state_q;
  logic [PhW-1:0] phase_q;
  logic [CW-1:0]  wait_cnt_q;
  logic [PW-1:0]  last_q;
  logic [PW-1:0]  prog_idx_q;
  logic [CW-1:0]  cycle_count_q;
  logic           dut_reset_q;
  logic           dut_start_q;
  logic           count_valid_q;
  logic           busy_q;
  logic           done_q;
  logic           timeout_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      wait_cnt_q    <= '0;
      last_q        <= '0;
      prog_idx_q    <= '0;
      cycle_count_q <= '0;
      dut_reset_q   <= 1'b0;
      dut_start_q   <= 1'b0;
      count_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      count_valid_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (go_i) begin
            // NumProgs==0 wraps to an all-ones last index, i.e. 2**PW programs
            last_q      <= num_progs_i - PW'(1);
            prog_idx_q  <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            dut_reset_q <= 1'b1;
            phase_q     <= '0;
            state_q     <= StRst;
          end
        end
        StRst: begin
          if (phase_q == RstLast) begin
            dut_reset_q <= 1'b0;
            dut_start_q <= 1'b1;
            phase_q     <= '0;
            state_q     <= StStart;
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StStart: begin
          // Ack is not looked at here: it may still be the previous program's halt flag
          if (phase_q == StartLast) begin
            dut_start_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= StWait;
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StWait: begin
          if (dut_ack_i) begin
            cycle_count_q <= wait_cnt_q;
            count_valid_q <= 1'b1;
            state_q       <= StReport;
          end else if (wait_cnt_q == TimeoutVal) begin
            timeout_q     <= 1'b1;
            cycle_count_q <= TimeoutVal;
            done_q        <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        StReport: begin
          if (prog_idx_q == last_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            prog_idx_q  <= prog_idx_q + PW'(1);
            dut_start_q <= 1'b1;
            phase_q     <= '0;
            state_q     <= StStart;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dut_reset_o   = dut_reset_q;
  assign dut_start_o   = dut_start_q;
  assign prog_idx_o    = prog_idx_q;
  assign cycle_count_o = cycle_count_q;
  assign count_valid_o = count_valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;

endmodule
